// File: rtl/std_mem_arb_pkg.sv
// rtl/std_mem_arb_pkg.sv - shared types and helpers for the std_mem_d1 arbiter
package std_mem_arb_pkg;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_ACCESS_ENC = 2'd1;
  localparam logic [1:0] ST_WAIT_ENC   = 2'd2;
  localparam logic [1:0] ST_RESP_ENC   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE_ENC,
    ACCESS = ST_ACCESS_ENC,
    WAIT   = ST_WAIT_ENC,
    RESP   = ST_RESP_ENC
  } arb_state_t;

  // Width of a requester index; at least one bit even for degenerate counts.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/std_rr_pick.sv
// rtl/std_rr_pick.sv - combinational requester picker; STD_MEM_ARB_FIXED_PRIO_EN selects fixed priority
module std_rr_pick
  import std_mem_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [PW-1:0] index,
  output logic          found
);

`ifdef STD_MEM_ARB_FIXED_PRIO_EN
  // The pointer has no meaning when the lowest index always wins.
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan from the top down so the lowest active index is the last one written.
  always_comb begin
    winner = '0;
    index  = '0;
    found  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
        index     = PW'(i);
        found     = 1'b1;
      end
    end
  end
`else
  // Visit candidates farthest-first from ptr so the nearest one after ptr wins;
  // k==N revisits ptr itself, so the previous owner is searched last.
  always_comb begin
    logic [PW-1:0] idx;
    winner = '0;
    index  = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = N; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
        index       = idx;
        found       = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/std_mem_d1_arbiter.sv
// rtl/std_mem_d1_arbiter.sv - shares one single-port std_mem_d1 among NUM_REQ requesters; STD_MEM_ARB_FIXED_PRIO_EN selects fixed priority
module std_mem_d1_arbiter
  import std_mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*IDX_SIZE-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [WIDTH-1:0]            rsp_data,
  output logic [IDX_SIZE-1:0]         mem_addr0,
  output logic [WIDTH-1:0]            mem_write_data,
  output logic                        mem_write_en,
  input  logic [WIDTH-1:0]            mem_read_data,
  input  logic                        mem_done
);

  localparam int PW = ptr_width(NUM_REQ);

  // Memory depth is descriptive only; nothing in the datapath depends on it.
  logic unused_size;
  assign unused_size = (SIZE > 0);

  arb_state_t          state_q, state_d;
  logic [PW-1:0]       rr_ptr_q;
  logic [PW-1:0]       owner_q;
  logic                we_q;
  logic [IDX_SIZE-1:0] addr_q;
  logic [WIDTH-1:0]    wdata_q;
  logic [WIDTH-1:0]    rdata_q;

  logic [NUM_REQ-1:0]  win_oh;
  logic [PW-1:0]       win_idx;
  logic                win_found;
  logic                take;

  std_rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .winner (win_oh),
    .index  (win_idx),
    .found  (win_found)
  );

  // Next state and all outputs; grants are only offered in IDLE and never while reset is held.
  always_comb begin
    state_d        = state_q;
    take           = 1'b0;
    gnt            = '0;
    rsp_valid      = '0;
    mem_addr0      = '0;
    mem_write_data = '0;
    mem_write_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found && reset) begin
          gnt     = win_oh;
          take    = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr0 = addr_q;
        if (we_q) begin
          mem_write_en   = 1'b1;
          mem_write_data = wdata_q;
          state_d        = WAIT;
        end else begin
          state_d = RESP;
        end
      end
      WAIT: begin
        if (mem_done) begin
          rsp_valid[owner_q] = 1'b1;
          state_d            = IDLE;
        end
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, winner fields sampled in the grant cycle, and read data captured during ACCESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= PW'(NUM_REQ - 1);
      owner_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        owner_q  <= win_idx;
        rr_ptr_q <= win_idx;
        we_q     <= req_we[win_idx];
        addr_q   <= req_addr[int'(win_idx) * IDX_SIZE +: IDX_SIZE];
        wdata_q  <= req_wdata[int'(win_idx) * WIDTH +: WIDTH];
      end
      if (state_q == ACCESS && !we_q) begin
        rdata_q <= mem_read_data;
      end
    end
  end

  assign rsp_data = rdata_q;

endmodule

// File: tb/tb_std_mem_d1_arbiter.sv
// tb/tb_std_mem_d1_arbiter.sv - directed self-checking bench for std_mem_d1_arbiter
module tb_std_mem_d1_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int S = 16;
  localparam int A = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   req_we;
  logic [N*A-1:0] req_addr;
  logic [N*W-1:0] req_wdata;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [A-1:0]   mem_addr0;
  logic [W-1:0]   mem_write_data;
  logic           mem_write_en;
  logic [W-1:0]   mem_read_data;
  logic           mem_done;

  int checks   = 0;
  int failures = 0;

  // Memory model: combinational read, write with a done pulse one cycle later.
  logic [W-1:0] mem [S];
  logic         pre_we;
  logic [A-1:0] pre_addr;
  logic [W-1:0] pre_data;
  logic         done_q;

  always #5 clk = ~clk;

  // Done follows write enable by one cycle.
  always @(posedge clk or negedge reset) begin
    if (!reset) done_q <= 1'b0;
    else        done_q <= mem_write_en;
  end

  // Array storage, written by the arbiter or by bench preload.
  always @(posedge clk) begin
    if (mem_write_en)  mem[mem_addr0] <= mem_write_data;
    else if (pre_we)   mem[pre_addr]  <= pre_data;
  end

  assign mem_read_data = mem[mem_addr0];
  assign mem_done      = done_q;

  std_mem_d1_arbiter #(
    .NUM_REQ  (N),
    .WIDTH    (W),
    .SIZE     (S),
    .IDX_SIZE (A)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .gnt            (gnt),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .mem_addr0      (mem_addr0),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data),
    .mem_done       (mem_done)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic preload(input logic [A-1:0] a, input logic [W-1:0] d);
    tick();
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic set_fields(input int i, input logic we, input logic [A-1:0] a, input logic [W-1:0] d);
    req_we[i]          = we;
    req_addr[i*A +: A] = a;
    req_wdata[i*W +: W] = d;
  endtask

  task automatic do_reset();
    req    = '0;
    reset  = 1'b0;
    tick();
    tick();
    reset  = 1'b1;
  endtask

  task automatic test_reset();
    req = 4'b1111;
    #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0000); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=%b", rsp_valid, 4'b0000); end
    checks++; if (mem_write_en !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_write_en); end
    checks++; if (mem_addr0 !== 4'd0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr0); end
    checks++; if (mem_write_data !== 32'd0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_write_data); end
    checks++; if (rsp_data !== 32'd0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    req   = '0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    tick();
    set_fields(2, 1'b0, 4'd5, 32'h0);
    req = 4'b0100;
    #1;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL read_gnt got=%b exp=%b", gnt, 4'b0100); end
    tick();
    req = '0;
    #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL read_access_gnt got=%b exp=0000", gnt); end
    checks++; if (mem_addr0 !== 4'd5) begin failures++; $display("FAIL read_addr got=%h exp=5", mem_addr0); end
    checks++; if (mem_write_en !== 1'b0) begin failures++; $display("FAIL read_we got=%b exp=0", mem_write_en); end
    tick();
    checks++; if (rsp_valid !== 4'b0100) begin failures++; $display("FAIL read_rsp_valid got=%b exp=%b", rsp_valid, 4'b0100); end
    checks++; if (rsp_data !== 32'hA5) begin failures++; $display("FAIL read_rsp_data got=%h exp=a5", rsp_data); end
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL read_rsp_gnt got=%b exp=0000", gnt); end
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL read_rsp_clear got=%b exp=0000", rsp_valid); end
    checks++; if (mem_addr0 !== 4'd0) begin failures++; $display("FAIL read_idle_addr got=%h exp=0", mem_addr0); end
  endtask

  task automatic test_single_write();
    set_fields(0, 1'b1, 4'd3, 32'h1234);
    req = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL write_gnt got=%b exp=%b", gnt, 4'b0001); end
    tick();
    req = '0;
    set_fields(0, 1'b0, 4'd0, 32'hFFFF_FFFF);
    #1;
    checks++; if (mem_write_en !== 1'b1) begin failures++; $display("FAIL write_we got=%b exp=1", mem_write_en); end
    checks++; if (mem_addr0 !== 4'd3) begin failures++; $display("FAIL write_addr got=%h exp=3", mem_addr0); end
    checks++; if (mem_write_data !== 32'h1234) begin failures++; $display("FAIL write_data got=%h exp=1234", mem_write_data); end
    tick();
    checks++; if (mem_write_en !== 1'b0) begin failures++; $display("FAIL write_wait_we got=%b exp=0", mem_write_en); end
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL write_rsp_valid got=%b exp=%b", rsp_valid, 4'b0001); end
    checks++; if (mem_write_data !== 32'd0) begin failures++; $display("FAIL write_wait_wdata got=%h exp=0", mem_write_data); end
    tick();
    set_fields(0, 1'b0, 4'd3, 32'h0);
    req = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL readback_gnt got=%b exp=%b", gnt, 4'b0001); end
    tick();
    req = '0;
    tick();
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL readback_rsp_valid got=%b exp=%b", rsp_valid, 4'b0001); end
    checks++; if (rsp_data !== 32'h1234) begin failures++; $display("FAIL readback_data got=%h exp=1234", rsp_data); end
    tick();
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp [5];
`ifdef STD_MEM_ARB_FIXED_PRIO_EN
    exp[0] = 4'b0001; exp[1] = 4'b0001; exp[2] = 4'b0001; exp[3] = 4'b0001; exp[4] = 4'b0001;
`else
    exp[0] = 4'b0001; exp[1] = 4'b0010; exp[2] = 4'b0100; exp[3] = 4'b1000; exp[4] = 4'b0001;
`endif
    do_reset();
    for (int i = 0; i < N; i++) set_fields(i, 1'b0, 4'd5, 32'h0);
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      #1;
      checks++; if (gnt !== exp[r]) begin failures++; $display("FAIL fair_gnt round=%0d got=%b exp=%b", r, gnt, exp[r]); end
      tick();
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL fair_access_gnt round=%0d got=%b exp=0000", r, gnt); end
      tick();
      checks++; if (rsp_valid !== exp[r] || gnt !== 4'b0000) begin failures++; $display("FAIL fair_rsp round=%0d rsp_valid=%b gnt=%b exp_rsp=%b exp_gnt=0000", r, rsp_valid, gnt, exp[r]); end
      tick();
    end
    req = '0;
  endtask

  task automatic test_late_request();
    do_reset();
    set_fields(3, 1'b0, 4'd5, 32'h0);
    req = 4'b1000;
    #1;
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL late_first_gnt got=%b exp=%b", gnt, 4'b1000); end
    tick();
    set_fields(1, 1'b0, 4'd9, 32'h0);
    req = 4'b0010;
    #1;
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL late_access_gnt got=%b exp=0000", gnt); end
    tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL late_resp_gnt got=%b exp=0000", gnt); end
    checks++; if (rsp_valid !== 4'b1000) begin failures++; $display("FAIL late_resp_valid got=%b exp=%b", rsp_valid, 4'b1000); end
    tick();
    set_fields(1, 1'b0, 4'd7, 32'h0);
    #1;
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL late_gnt got=%b exp=%b", gnt, 4'b0010); end
    tick();
    req = '0;
    set_fields(1, 1'b0, 4'd9, 32'h0);
    #1;
    checks++; if (mem_addr0 !== 4'd7) begin failures++; $display("FAIL late_sampled_addr got=%h exp=7", mem_addr0); end
    tick();
    checks++; if (rsp_valid !== 4'b0010) begin failures++; $display("FAIL late_rsp_valid got=%b exp=%b", rsp_valid, 4'b0010); end
    checks++; if (rsp_data !== 32'h77) begin failures++; $display("FAIL late_rsp_data got=%h exp=77", rsp_data); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    set_fields(0, 1'b1, 4'd10, 32'hDEAD);
    req = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rstwait_gnt got=%b exp=%b", gnt, 4'b0001); end
    tick();
    req = '0;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rstwait_rsp_valid got=%b exp=0000", rsp_valid); end
    checks++; if (mem_write_en !== 1'b0 || gnt !== 4'b0000 || mem_addr0 !== 4'd0) begin failures++; $display("FAIL rstwait_outputs we=%b gnt=%b addr=%h exp=0", mem_write_en, gnt, mem_addr0); end
    tick();
    tick();
    reset = 1'b1;
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rstwait_after_rsp got=%b exp=0000", rsp_valid); end
    set_fields(2, 1'b0, 4'd5, 32'h0);
    req = 4'b0100;
    #1;
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL rstwait_req2_gnt got=%b exp=%b", gnt, 4'b0100); end
    tick();
    req = '0;
    tick();
    checks++; if (rsp_valid !== 4'b0100) begin failures++; $display("FAIL rstwait_req2_rsp got=%b exp=%b", rsp_valid, 4'b0100); end
    tick();
  endtask

  task automatic test_wrap();
    logic [N-1:0] exp_second;
`ifdef STD_MEM_ARB_FIXED_PRIO_EN
    exp_second = 4'b0001;
`else
    exp_second = 4'b1000;
`endif
    set_fields(3, 1'b0, 4'd5, 32'h0);
    req = 4'b1000;
    #1;
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL wrap_setup_gnt got=%b exp=%b", gnt, 4'b1000); end
    tick();
    req = '0;
    tick();
    tick();
    set_fields(0, 1'b0, 4'd7, 32'h0);
    req = 4'b1001;
    #1;
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL wrap_first_gnt got=%b exp=%b", gnt, 4'b0001); end
    tick();
    tick();
    checks++; if (rsp_data !== 32'h77) begin failures++; $display("FAIL wrap_first_data got=%h exp=77", rsp_data); end
    tick();
    checks++; if (gnt !== exp_second) begin failures++; $display("FAIL wrap_second_gnt got=%b exp=%b", gnt, exp_second); end
    tick();
    req = '0;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    pre_we    = 1'b0;
    pre_addr  = '0;
    pre_data  = '0;
    preload(4'd5, 32'hA5);
    preload(4'd7, 32'h77);
    preload(4'd9, 32'h99);
    test_reset();
    test_single_read();
    test_single_write();
    test_fairness();
    test_late_request();
    test_reset_mid_wait();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
